square_stim_seq: RTL and testbench

- Self-contained stimulus sequencer and response compactor for the 64-bit squaring netlist (a -> asquared).
- Drives a[63:0] using a priority-banded pattern:
  - core band a[43:20] from a 24-bit LFSR;
  - auxiliary bands a[19:12] and a[51:44] from the step counter;
  - all other bits held at 0.
- After a settle window, compacts the observed slice asquared[95:64] into a 32-bit MISR signature and compares it against a golden value.
- Sits between the fault-injection harness and the squaring DUT, replacing open-loop testbench stimulus.

---
 rtl/square_stim_seq.sv | 143 ++++++++++++++
 tb/tb_square_stim_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/square_stim_seq.sv
// Stimulus sequencer and MISR response compactor for the 64-bit squaring netlist.
// Drives banded LFSR/counter patterns on a_out and folds sq_in[95:64] into a signature.
module square_stim_seq #(
  parameter int unsigned STEPS       = 512,
  parameter int unsigned CORE_PERIOD = 2,
  parameter int unsigned AUX_PERIOD  = 8,
  parameter int unsigned SETTLE_CYC  = 1,
  parameter logic [23:0] LFSR_SEED   = 24'h000001,
  parameter logic [31:0] MISR_POLY   = 32'h04C11DB7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [31:0]  golden,
  input  logic [127:0] sq_in,
  output logic [63:0]  a_out,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [31:0]  signature,
  output logic [15:0]  step_cnt
);

  localparam logic [23:0] Seed       = (LFSR_SEED == 24'd0) ? 24'h000001 : LFSR_SEED;
  localparam logic [15:0] LastStep   = 16'(STEPS - 1);
  localparam logic [15:0] CoreMask   = 16'(CORE_PERIOD - 1);
  localparam logic [15:0] AuxMask    = 16'(AUX_PERIOD - 1);
  localparam logic [7:0]  SettleLast = 8'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {StIdle, StApply, StSettle, StCapture, StFinish} state_e;

  state_e       state_q, state_d;
  logic [23:0]  lfsr_q, lfsr_d;
  logic [63:0]  a_q, a_d;
  logic [31:0]  sig_q, sig_d;
  logic         pass_q, pass_d;
  logic [15:0]  step_q, step_d;
  logic [7:0]   settle_q, settle_d;
  logic [23:0]  lfsr_next;
  logic [31:0]  misr_next;
  logic         unused_sq;

  // Only the observed slice of the square feeds the compactor.
  assign unused_sq = ^{sq_in[127:96], sq_in[63:0]};

  assign lfsr_next = {lfsr_q[22:0], lfsr_q[23] ^ lfsr_q[22] ^ lfsr_q[21] ^ lfsr_q[16]};
  assign misr_next = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0) ^ sq_in[95:64];

  assign busy      = (state_q == StApply) || (state_q == StSettle) || (state_q == StCapture);
  assign done      = (state_q == StFinish) && !abort;
  assign a_out     = a_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign step_cnt  = step_q;

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    a_d      = a_q;
    sig_d    = sig_q;
    pass_d   = pass_q;
    step_d   = step_q;
    settle_d = settle_q;
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      a_d     = '0;
      pass_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StApply;
            step_d  = '0;
            lfsr_d  = Seed;
            sig_d   = '1;
            pass_d  = 1'b0;
          end
        end
        StApply: begin
          if (((step_q & CoreMask) == 16'd0) && (step_q != 16'd0)) begin
            lfsr_d      = lfsr_next;
            a_d[43:20]  = lfsr_next;
          end else begin
            a_d[43:20]  = lfsr_q;
          end
          // Auxiliary bands reload on period boundaries and hold in between.
          if ((step_q & AuxMask) == 16'd0) begin
            a_d[19:12] = step_q[7:0];
            a_d[51:44] = step_q[7:0];
          end
          a_d[11:0]  = '0;
          a_d[63:52] = '0;
          settle_d   = '0;
          state_d    = (SETTLE_CYC > 0) ? StSettle : StCapture;
        end
        StSettle: begin
          if (settle_q == SettleLast) begin
            state_d = StCapture;
          end else begin
            settle_d = settle_q + 8'd1;
          end
        end
        StCapture: begin
          sig_d = misr_next;
          if (step_q == LastStep) begin
            state_d = StFinish;
          end else begin
            step_d  = step_q + 16'd1;
            state_d = StApply;
          end
        end
        StFinish: begin
          pass_d  = (sig_q == golden);
          a_d     = '0;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      lfsr_q   <= Seed;
      a_q      <= '0;
      sig_q    <= '0;
      pass_q   <= 1'b0;
      step_q   <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      a_q      <= a_d;
      sig_q    <= sig_d;
      pass_q   <= pass_d;
      step_q   <= step_d;
      settle_q <= settle_d;
    end
  end

endmodule

// File: tb/tb_square_stim_seq.sv
// Randomized self-checking bench for square_stim_seq against a step-indexed timing model.
module tb_square_stim_seq;

  localparam int N  = 24;   // steps, main instance
  localparam int S  = 2;    // settle cycles, main instance
  localparam int P  = S + 2;
  localparam int CP = 2;
  localparam int AP = 8;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [31:0]  golden = '0;
  logic [127:0] sq_in = '0;
  logic [63:0]  a_out, a_out_s;
  logic         busy, busy_s, done, done_s, pass, pass_s;
  logic [31:0]  signature, sig_s;
  logic [15:0]  step_cnt, step_s;

  int total = 0;
  int bad   = 0;

  // model state
  bit          m_run  = 1'b0;
  int          m_e    = 0;
  int          m_step = 0;
  logic [31:0] m_sig  = '0;
  logic        m_pass = 1'b0;
  logic [63:0] m_a    = '0;
  int          gmode  = 2;
  bit          zero_sq = 1'b1;

  always #5 clk = ~clk;

  square_stim_seq #(
    .STEPS(N), .CORE_PERIOD(CP), .AUX_PERIOD(AP), .SETTLE_CYC(S),
    .LFSR_SEED(24'h000000), .MISR_POLY(POLY)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .golden(golden), .sq_in(sq_in),
    .a_out(a_out), .busy(busy), .done(done), .pass(pass), .signature(signature),
    .step_cnt(step_cnt)
  );

  square_stim_seq #(
    .STEPS(4), .SETTLE_CYC(1)
  ) u_small (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .golden(golden), .sq_in(sq_in),
    .a_out(a_out_s), .busy(busy_s), .done(done_s), .pass(pass_s), .signature(sig_s),
    .step_cnt(step_s)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] lfsr_nxt(input logic [23:0] v);
    return {v[22:0], v[23] ^ v[22] ^ v[21] ^ v[16]};
  endfunction

  // Expected drive for step s, computed directly from the step index.
  function automatic logic [63:0] pattern(input int s);
    logic [23:0] core;
    logic [7:0]  aux;
    core = 24'h000001;
    for (int k = 0; k < s / CP; k++) core = lfsr_nxt(core);
    aux = 8'(s - (s % AP));
    return {12'h000, aux, core, aux, 12'h000};
  endfunction

  function automatic logic [31:0] misr(input logic [31:0] sg, input logic [31:0] d);
    return {sg[30:0], 1'b0} ^ (sg[31] ? POLY : 32'h0) ^ d;
  endfunction

  // Advance the model across one clock edge; m_e counts edges since the start edge.
  task automatic model_step(input bit st, input bit ab, input logic [31:0] d);
    if (m_run) begin
      if (ab) begin
        m_run = 1'b0; m_a = '0; m_pass = 1'b0;
      end else if (m_e == N * P) begin
        m_run = 1'b0; m_pass = (m_sig == golden); m_a = '0;
      end else begin
        m_e++;
        if ((m_e - 1) % P == 0) m_a = pattern((m_e - 1) / P);
        if (m_e % P == 0) begin
          m_sig  = misr(m_sig, d);
          m_step = (m_e / P > N - 1) ? N - 1 : m_e / P;
        end
      end
    end else if (st && !ab) begin
      m_run = 1'b1; m_e = 0; m_step = 0; m_sig = '1; m_pass = 1'b0;
    end
  endtask

  task automatic compare();
    chk("a_out",     a_out,     m_a);
    chk("busy",      busy,      m_run && (m_e < N * P));
    chk("done",      done,      m_run && (m_e == N * P));
    chk("pass",      pass,      m_pass);
    chk("signature", signature, m_sig);
    chk("step_cnt",  step_cnt,  16'(m_step));
  endtask

  task automatic tick(input bit st, input bit ab);
    logic [127:0] sq;
    sq = zero_sq ? 128'h0 : {$urandom, $urandom, $urandom, $urandom};
    sq_in = sq;
    start = st;
    abort = ab;
    if (m_run && (m_e == N * P))
      golden = (gmode == 0) ? m_sig : (gmode == 1) ? (m_sig ^ 32'h1) : $urandom;
    else
      golden = $urandom;
    model_step(st, ab, sq[95:64]);
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    compare();
  endtask

  task automatic run_to_idle();
    for (int k = 0; k < N * P + 10 && m_run; k++) tick(1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_a_out", a_out, 64'h0);
    chk("rst_sig",   signature, 32'h0);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);

    // Run 1: zero response, matching golden, stray start at step 3.
    zero_sq = 1'b1;
    gmode   = 0;
    tick(1'b1, 1'b0);
    while (m_run) begin
      tick((m_e == 3 * P + 1), 1'b0);
      if (m_e <= 13) begin
        chk("small_done", done_s, (m_e == 12) && m_run);
        chk("small_busy", busy_s, m_e < 12);
      end
      if (m_e == 3)         chk("small_sig_first", sig_s, 32'hFB3EE249);
      if (m_e == 1)         chk("core_step0", a_out[43:20], 24'h000001);
      if (m_e == 1)         chk("aux_step0", {a_out[51:44], a_out[19:12]}, 16'h0000);
      if (m_e == P)         chk("sig_first", signature, 32'hFB3EE249);
      if (m_e == 2 * P + 1) chk("core_step2", a_out[43:20], 24'h000002);
      if (m_e == 8 * P + 1) chk("aux_step8", {a_out[51:44], a_out[19:12]}, 16'h0808);
      if (m_e == 16 * P)    chk("aux_step15", {a_out[51:44], a_out[19:12]}, 16'h0808);
      if (m_e > N * P + 2) break;
    end
    chk("run1_pass", pass, 1'b1);
    chk("small_idle", busy_s, 1'b0);

    // Run 2: random response, golden off by one bit.
    zero_sq = 1'b0;
    gmode   = 1;
    tick(1'b1, 1'b0);
    run_to_idle();
    chk("run2_pass", pass, 1'b0);

    // Run 3: abort during settle of step 5, then a clean restart.
    gmode = 0;
    tick(1'b1, 1'b0);
    for (int k = 0; k < N * P && m_e != 5 * P + 1; k++) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_a",    a_out, 64'h0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("restart_core", a_out[43:20], 24'h000001);
    run_to_idle();
    chk("run3_pass", pass, 1'b1);

    // Run 4: asynchronous reset at step 7.
    tick(1'b1, 1'b0);
    for (int k = 0; k < N * P && m_e != 7 * P + 1; k++) tick(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_a",    a_out, 64'h0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_pass", pass, 1'b0);
    chk("mid_rst_sig",  signature, 32'h0);
    chk("mid_rst_step", step_cnt, 16'h0);
    m_run = 1'b0; m_e = 0; m_step = 0; m_sig = '0; m_pass = 1'b0; m_a = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);

    // Random traffic: sporadic start/abort, mixed golden outcomes.
    for (int i = 0; i < 600; i++) begin
      gmode = $urandom_range(0, 2);
      tick(($urandom_range(0, 5) == 0), ($urandom_range(0, 59) == 0));
    end
    run_to_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
